pc_checkpoint_monitor: RTL

PC_CHECKPOINT_MONITOR -- requirements
Module: pc_checkpoint_monitor

---
 rtl/pc_checkpoint_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_checkpoint_monitor.sv
// rtl/pc_checkpoint_monitor.sv - in-order PC checkpoint capture with halt and run-cycle timeout
module pc_checkpoint_monitor #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_CP    = 8,
  parameter int                TIMEOUT   = 4096,
  parameter logic [ADDR_W-1:0] HALT_ADDR = '0,
  parameter int                IDX_W     = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [4:0]        cfg_reg,
  output logic [4:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              cp_valid,
  input  logic              cp_ready,
  output logic [IDX_W-1:0]  cp_idx,
  output logic [DATA_W-1:0] cp_data,
  output logic [31:0]       cp_cycle,
  output logic              done,
  output logic              timeout,
  output logic              missed
);

  // k must reach NUM_CP to mark the table as exhausted
  localparam int          K_W     = $clog2(NUM_CP + 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t            state, state_next;
  logic [K_W-1:0]    k;
  logic [31:0]       cyc;
  logic              halt_pend;
  logic [ADDR_W-1:0] tbl_addr [NUM_CP];
  logic [4:0]        tbl_reg  [NUM_CP];
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        cur_reg;
  logic              hit, halt, to_hit;

  always_comb begin
    cur_addr = '0;
    cur_reg  = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (k == K_W'(i)) begin
        cur_addr = tbl_addr[i];
        cur_reg  = tbl_reg[i];
      end
    end
  end

  assign hit    = (k < K_W'(NUM_CP)) && (instr_addr == cur_addr);
  assign halt   = (instr_addr == HALT_ADDR);
  assign to_hit = (cyc == TO_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (to_hit)    state_next = S_DONE;
        else if (hit)  state_next = S_HOLD;
        else if (halt) state_next = S_DONE;
      end
      S_HOLD: begin
        if (to_hit)        state_next = S_DONE;
        else if (cp_ready) state_next = (halt_pend || halt) ? S_DONE : S_RUN;
      end
      S_DONE: if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      cyc       <= '0;
      halt_pend <= 1'b0;
      cp_idx    <= '0;
      cp_data   <= '0;
      cp_cycle  <= '0;
      timeout   <= 1'b0;
      missed    <= 1'b0;
      for (int i = 0; i < NUM_CP; i++) begin
        tbl_addr[i] <= '0;
        tbl_reg[i]  <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_IDLE && cfg_we) begin
            for (int i = 0; i < NUM_CP; i++) begin
              if (cfg_idx == IDX_W'(i)) begin
                tbl_addr[i] <= cfg_addr;
                tbl_reg[i]  <= cfg_reg;
              end
            end
          end
          if (start) begin
            k         <= '0;
            cyc       <= '0;
            halt_pend <= 1'b0;
            timeout   <= 1'b0;
            missed    <= 1'b0;
          end
        end
        S_RUN: begin
          if (cyc != '1) cyc <= cyc + 32'd1;
          if (to_hit) begin
            timeout <= 1'b1;
          end else if (hit) begin
            cp_data   <= reg_data;
            cp_idx    <= k[IDX_W-1:0];
            cp_cycle  <= cyc;
            k         <= k + K_W'(1);
            halt_pend <= halt;
          end
        end
        S_HOLD: begin
          if (cyc != '1) cyc <= cyc + 32'd1;
          if (to_hit) begin
            timeout <= 1'b1;
          end else begin
            // a checkpoint passing while the previous capture is unacknowledged is lost
            if (hit) begin
              missed <= 1'b1;
              k      <= k + K_W'(1);
            end
            if (halt) halt_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done     = (state == S_DONE);
    cp_valid = (state == S_HOLD);
    reg_sel  = cur_reg;
  end

endmodule
